qam_symbol_packer: RTL
======================

Name: qam_symbol_packer

Overview:
- Upstream feeder for the 16-QAM mapper.
- Accepts a byte stream with a valid/ready handshake and frame delimiters, buffers the bytes in a small FIFO, and splits each byte into two 4-bit symbols.
- Emits one symbol per cycle with start/done framing pulses that drive the mapper's symbol, data_valid_i, start and done_flag_i inputs directly.

Parameters:
- FIFO_DEPTH, 4: byte FIFO entries; power of two, at least 2.
- MSB_FIRST, 1: 1 emits byte[7:4] first and byte[3:0] second; 0 reverses the order.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_i  input  1  one-cycle pulse that opens a frame.
- data_i  input  8  payload byte.
- data_valid_i  input  1  data_i is valid.
- last_i  input  1  qualifies data_i as the final byte of the frame.
- data_ready_o  output  1  the block can accept a byte this cycle.
- symbol_o  output  4  symbol to the mapper.
- symbol_valid_o  output  1  symbol_o is valid.
- start_o  output  1  pulse coincident with the first symbol of the frame.
- done_flag_o  output  1  pulse coincident with the last symbol of the frame.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset: all outputs are 0. FIFO is emptied, FSM goes to IDLE, the first-symbol flag is cleared. Reset asserted mid-frame discards all buffered data with no done pulse.
- FSM states:
  - IDLE: data_ready_o=0. start_i moves to FILL.
  - FILL: data_ready_o = FIFO not full. A byte is accepted when data_valid_i && data_ready_o; it is written with its last bit. An accepted byte with last_i=1 moves to DRAIN.
  - DRAIN: data_ready_o=0. When the FIFO is empty and no symbol is pending, return to IDLE.
- start_i outside IDLE is ignored. data_valid_i in IDLE is ignored, with no write.
- Splitter: a two-phase counter, HI then LO, pops one FIFO entry per two symbols.
  - The pop happens when the FIFO is non-empty and the phase is HI. The byte is held in a register; the second nibble is emitted next cycle.
  - Phase toggles on every emitted symbol. No idle cycle between consecutive bytes when the FIFO is non-empty, so 1 symbol/cycle sustained.
  - No backpressure from the mapper.
- Outputs are registered.
- Latency: a byte accepted on edge k into an empty FIFO gives its first symbol valid after edge k+1 and its second symbol after edge k+2.
- start_o is 1 together with the first symbol after start_i, cleared thereafter.
- done_flag_o is 1 together with the second symbol of the byte tagged last.
- A frame containing one byte gives start_o and done_flag_o on different symbols, first and second respectively.
- Simultaneous FIFO write and read in the same cycle are both performed; count is unchanged.
- Pointers are log2(FIFO_DEPTH) bits, wrapping naturally. Full/empty come from an occupancy counter 0..FIFO_DEPTH.
- Between symbols: symbol_valid_o=0 and symbol_o holds its last value.

Optional Feature:
- Macro: QAM_SCRAMBLER_EN.
- When defined, each symbol is XORed with a 4-bit mask from an additive 7-bit LFSR s (polynomial x^7+x^4+1).
  - Per bit step: fb = s[6]^s[3], then s = {s[5:0], fb}.
  - Four steps per symbol; the first fb produced goes to mask bit 3.
  - s is seeded to 7'h7F when start_i is accepted in IDLE.
  - With this seed the masks are 4'h0, 4'hE, and so on.
- Not defined: symbols pass through unmodified and no LFSR logic exists.

Decomposition:
- Shared package qam_pkg holds:
  - SYMBOL_W=4 and BYTE_W=8;
  - the FSM state enum (IDLE, FILL, DRAIN);
  - LFSR_SEED=7'h7F and LFSR taps.
- One sub-module: qam_byte_fifo, a parameterised synchronous FIFO, FIFO_DEPTH × 9 bits (byte plus last).
- The FSM, splitter and scrambler live in the top.

Test Plan:
- start_i, then byte 0xA5 with last_i=1 into an empty FIFO: symbol 4'hA appears with start_o=1 after edge k+1, then 4'h5 with done_flag_o=1 after edge k+2, then IDLE.
- MSB_FIRST=0, bytes 0x12, 0x34 (last): symbols 2,1,4,3 on consecutive cycles, no gaps.
- Push 8 bytes back-to-back with FIFO_DEPTH=4: data_ready_o drops when occupancy reaches 4. All 16 symbols are emitted in order at 1/cycle, with no loss or duplication.
- data_valid_i pulses and a second start_i while in IDLE/DRAIN: no bytes accepted, no extra start_o.
- rst asserted mid-frame with 3 bytes buffered: all outputs 0 immediately and asynchronously, no done_flag_o. A new frame after release starts cleanly.
- QAM_SCRAMBLER_EN defined, start_i, bytes 0x00, 0x00 (last): symbols 4'h0, 4'hE, then masks continue. The LFSR reseeds to 7'h7F on the next frame.

Source files
------------

// File: rtl/qam_pkg.sv
// Shared types and constants for the 16-QAM symbol packer.
// The LFSR helper is only referenced when QAM_SCRAMBLER_EN is defined.
package qam_pkg;

    localparam int SYMBOL_W = 4;
    localparam int BYTE_W   = 8;

    localparam int              LFSR_W      = 7;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h7F;
    localparam int              LFSR_TAP_HI = 6;   // x^7 term
    localparam int              LFSR_TAP_LO = 3;   // x^4 term

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } state_t;

    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } fifo_entry_t;

    typedef struct packed {
        logic [SYMBOL_W-1:0] mask;
        logic [LFSR_W-1:0]   next_s;
    } lfsr_out_t;

    // Four serial steps of the additive scrambler; the first feedback bit lands in mask[3].
    function automatic lfsr_out_t lfsr_step4(input logic [LFSR_W-1:0] s);
        lfsr_out_t         r;
        logic [LFSR_W-1:0] st;
        logic              fb;
        st = s;
        r  = '0;
        for (int i = 0; i < SYMBOL_W; i++) begin
            fb                     = st[LFSR_TAP_HI] ^ st[LFSR_TAP_LO];
            r.mask[SYMBOL_W-1-i]   = fb;
            st                     = {st[LFSR_W-2:0], fb};
        end
        r.next_s = st;
        return r;
    endfunction

endpackage

// File: rtl/qam_byte_fifo.sv
// Synchronous FIFO of byte+last entries with a show-ahead read port.
// Full/empty come from an occupancy counter; pointers wrap naturally.
module qam_byte_fifo
    import qam_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  fifo_entry_t wr_data,
    input  logic        rd_en,
    output fifo_entry_t rd_data,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fifo_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             wr_fire;
    logic             rd_fire;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: non-blocking updates so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_fire) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/qam_symbol_packer.sv
// Byte-to-nibble packer feeding the 16-QAM mapper: frame FSM, FIFO, HI/LO splitter.
// Optional additive scrambler enabled by defining QAM_SCRAMBLER_EN.
module qam_symbol_packer
    import qam_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [BYTE_W-1:0]   data_i,
    input  logic                data_valid_i,
    input  logic                last_i,
    output logic                data_ready_o,
    output logic [SYMBOL_W-1:0] symbol_o,
    output logic                symbol_valid_o,
    output logic                start_o,
    output logic                done_flag_o
);

    state_t              state_q;
    state_t              state_d;
    fifo_entry_t         wr_entry;
    fifo_entry_t         head;
    fifo_entry_t         hold_q;
    logic                fifo_full;
    logic                fifo_empty;
    logic                wr_fire;
    logic                pop;
    logic                emit;
    logic                start_accept;
    logic                phase_lo_q;
    logic                first_pending_q;
    logic [SYMBOL_W-1:0] first_nib;
    logic [SYMBOL_W-1:0] second_nib;
    logic [SYMBOL_W-1:0] scr_mask;

    assign wr_entry     = '{last: last_i, data: data_i};
    assign wr_fire      = data_valid_i && data_ready_o;
    assign start_accept = (state_q == IDLE) && start_i;
    assign pop          = !phase_lo_q && !fifo_empty;
    assign emit         = pop || phase_lo_q;

    assign first_nib  = MSB_FIRST ? head.data[BYTE_W-1 -: SYMBOL_W]   : head.data[SYMBOL_W-1:0];
    assign second_nib = MSB_FIRST ? hold_q.data[SYMBOL_W-1:0]         : hold_q.data[BYTE_W-1 -: SYMBOL_W];

    qam_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_fire),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: defaults first so no path through this block infers a latch.
    always_comb begin
        state_d      = state_q;
        data_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = FILL;
            end
            FILL: begin
                data_ready_o = !fifo_full;
                if (wr_fire && last_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (fifo_empty && !phase_lo_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef QAM_SCRAMBLER_EN
    logic [LFSR_W-1:0] lfsr_q;
    lfsr_out_t         lfsr_nx;

    assign lfsr_nx  = lfsr_step4(lfsr_q);
    assign scr_mask = lfsr_nx.mask;

    // Reseeded per frame so every frame sees the same mask sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               lfsr_q <= LFSR_SEED;
        else if (start_accept) lfsr_q <= LFSR_SEED;
        else if (emit)         lfsr_q <= lfsr_nx.next_s;
    end
`else
    assign scr_mask = '0;
`endif

    // HI phase pops a byte and emits its first nibble; LO phase emits the held second nibble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_lo_q      <= 1'b0;
            first_pending_q <= 1'b0;
            hold_q          <= '0;
            symbol_o        <= '0;
            symbol_valid_o  <= 1'b0;
            start_o         <= 1'b0;
            done_flag_o     <= 1'b0;
        end else begin
            symbol_valid_o <= 1'b0;
            start_o        <= 1'b0;
            done_flag_o    <= 1'b0;
            if (pop) begin
                symbol_o        <= first_nib ^ scr_mask;
                symbol_valid_o  <= 1'b1;
                start_o         <= first_pending_q;
                first_pending_q <= 1'b0;
                hold_q          <= head;
                phase_lo_q      <= 1'b1;
            end else if (phase_lo_q) begin
                symbol_o       <= second_nib ^ scr_mask;
                symbol_valid_o <= 1'b1;
                done_flag_o    <= hold_q.last;
                phase_lo_q     <= 1'b0;
            end
            if (start_accept) first_pending_q <= 1'b1;
        end
    end

endmodule
